// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg
// Shared types and constants for the CPU data-port bus bridge.
//   bridge_state_t   : bridge FSM states
//   WORD_W / BE_W    : data word and byte-enable widths
//   ERR_READDATA_DEF : value handed to the CPU on an aborted or rejected read
package mips_bus_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    localparam logic [WORD_W-1:0] ERR_READDATA_DEF = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bridge_state_t;

endpackage

// File: rtl/data_bus_bridge_if.sv
// data_bus_bridge_if
// Avalon-style word bus with wait-request flow control.
// The same interface type is used on both sides of the bridge:
//   master : address, read, write, writedata, byteenable out; readdata, waitrequest in
//   slave  : the reverse
interface data_bus_bridge_if;
    import mips_bus_pkg::*;

    logic [WORD_W-1:0] address;
    logic              read;
    logic              write;
    logic [WORD_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic [WORD_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter
// Counts wait-request cycles of the current bus transaction.
//   clk, reset : system clock, async active-high reset
//   i_clear    : synchronous clear (held while no transaction is in flight)
//   i_enable   : count one waited cycle
//   o_expired  : count has reached LIMIT-1; the count saturates there
module bus_timeout_counter #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int              CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/data_bus_bridge.sv
// data_bus_bridge
// Converts the CPU's combinational-read / single-cycle-write data port into
// registered Avalon-style transactions and stalls the CPU until each completes.
//   clk, reset       : system clock, async active-high reset
//   cpu (slave)      : CPU data port; cpu.waitrequest mirrors the stall
//   mem (master)     : registered bus toward the wait-stated data memory
//   cpu_clock_enable : CPU clock enable, low = stall
//   bus_error        : sticky flag for misaligned, conflicting or timed-out accesses
module data_bus_bridge
    import mips_bus_pkg::*;
#(
    parameter int                TIMEOUT_CYCLES = 1023,
    parameter logic [WORD_W-1:0] ERR_READDATA   = ERR_READDATA_DEF
) (
    input  logic               clk,
    input  logic               reset,
    data_bus_bridge_if.slave   cpu,
    data_bus_bridge_if.master  mem,
    output logic               cpu_clock_enable,
    output logic               bus_error
);

    bridge_state_t     r_state, w_nxt_state;
    logic [WORD_W-1:0] r_mem_address, w_nxt_mem_address;
    logic              r_mem_read, w_nxt_mem_read;
    logic              r_mem_write, w_nxt_mem_write;
    logic [WORD_W-1:0] r_mem_writedata, w_nxt_mem_writedata;
    logic [BE_W-1:0]   r_mem_byteenable, w_nxt_mem_byteenable;
    logic [WORD_W-1:0] r_cpu_readdata, w_nxt_cpu_readdata;
    logic              r_bus_error, w_nxt_bus_error;

    logic w_req;
    logic w_valid_req;
    logic w_expired;

    assign w_req       = cpu.read || cpu.write;
    assign w_valid_req = (cpu.address[1:0] == 2'b00) && (cpu.read != cpu.write);

    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (r_state != BUSY),
        .i_enable  ((r_state == BUSY) && mem.waitrequest),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= IDLE;
            r_mem_address    <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_writedata  <= '0;
            r_mem_byteenable <= '0;
            r_cpu_readdata   <= '0;
            r_bus_error      <= 1'b0;
        end else begin
            r_state          <= w_nxt_state;
            r_mem_address    <= w_nxt_mem_address;
            r_mem_read       <= w_nxt_mem_read;
            r_mem_write      <= w_nxt_mem_write;
            r_mem_writedata  <= w_nxt_mem_writedata;
            r_mem_byteenable <= w_nxt_mem_byteenable;
            r_cpu_readdata   <= w_nxt_cpu_readdata;
            r_bus_error      <= w_nxt_bus_error;
        end
    end

    always_comb begin
        w_nxt_state          = r_state;
        w_nxt_mem_address    = r_mem_address;
        w_nxt_mem_read       = r_mem_read;
        w_nxt_mem_write      = r_mem_write;
        w_nxt_mem_writedata  = r_mem_writedata;
        w_nxt_mem_byteenable = r_mem_byteenable;
        w_nxt_cpu_readdata   = r_cpu_readdata;
        w_nxt_bus_error      = r_bus_error;

        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_valid_req) begin
                        w_nxt_mem_address    = cpu.address;
                        w_nxt_mem_writedata  = cpu.writedata;
                        // reads always fetch the full word
                        w_nxt_mem_byteenable = cpu.read ? {BE_W{1'b1}} : cpu.byteenable;
                        w_nxt_mem_read       = cpu.read;
                        w_nxt_mem_write      = cpu.write;
                        w_nxt_state          = BUSY;
                    end else begin
                        w_nxt_bus_error    = 1'b1;
                        w_nxt_cpu_readdata = ERR_READDATA;
                        w_nxt_state        = DONE;
                    end
                end
            end
            BUSY: begin
                if (!mem.waitrequest) begin
                    w_nxt_mem_read  = 1'b0;
                    w_nxt_mem_write = 1'b0;
                    if (r_mem_read) begin
                        w_nxt_cpu_readdata = mem.readdata;
                    end
                    w_nxt_state = DONE;
                end else if (w_expired) begin
                    w_nxt_mem_read     = 1'b0;
                    w_nxt_mem_write    = 1'b0;
                    w_nxt_bus_error    = 1'b1;
                    w_nxt_cpu_readdata = ERR_READDATA;
                    w_nxt_state        = DONE;
                end
            end
            DONE: begin
                // CPU retires on this edge; its request lines still show the old access
                w_nxt_state = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    assign cpu_clock_enable = !((r_state == IDLE) && w_req) && (r_state != BUSY);

    assign cpu.readdata    = r_cpu_readdata;
    assign cpu.waitrequest = !cpu_clock_enable;

    assign mem.address    = r_mem_address;
    assign mem.read       = r_mem_read;
    assign mem.write      = r_mem_write;
    assign mem.writedata  = r_mem_writedata;
    assign mem.byteenable = r_mem_byteenable;

    assign bus_error = r_bus_error;

endmodule

// File: tb/tb_data_bus_bridge.sv
// tb_data_bus_bridge
// Directed self-checking bench for data_bus_bridge (timeout shortened to 8 cycles).
module tb_data_bus_bridge;
    import mips_bus_pkg::*;

    logic clk;
    logic reset;
    logic cpu_clock_enable;
    logic bus_error;

    int n_tests;
    int n_fail;
    int n_stall;
    int n_busy;
    int n_rd_seen;

    data_bus_bridge_if cpu_if ();
    data_bus_bridge_if mem_if ();

    data_bus_bridge #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cpu              (cpu_if.slave),
        .mem              (mem_if.master),
        .cpu_clock_enable (cpu_clock_enable),
        .bus_error        (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_if.read       = 1'b0;
        cpu_if.write      = 1'b0;
        cpu_if.address    = 32'h0;
        cpu_if.writedata  = 32'h0;
        cpu_if.byteenable = 4'h0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        cpu_idle();
        mem_if.waitrequest = 1'b0;
        mem_if.readdata    = 32'h0;

        // reset state
        #12;
        chk1("rst_mem_read", mem_if.read, 1'b0);
        chk1("rst_mem_write", mem_if.write, 1'b0);
        chk("rst_mem_address", mem_if.address, 32'h0);
        chk("rst_cpu_readdata", cpu_if.readdata, 32'h0);
        chk1("rst_bus_error", bus_error, 1'b0);
        chk1("rst_ce", cpu_clock_enable, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        step();

        // zero-wait write
        cpu_if.address    = 32'h0000_1000;
        cpu_if.writedata  = 32'h1234_5678;
        cpu_if.byteenable = 4'hF;
        cpu_if.write      = 1'b1;
        #1;
        chk1("wr_idle_ce", cpu_clock_enable, 1'b0);
        chk1("wr_idle_cpu_wait", cpu_if.waitrequest, 1'b1);
        step();
        chk1("wr_busy_mem_write", mem_if.write, 1'b1);
        chk1("wr_busy_mem_read", mem_if.read, 1'b0);
        chk("wr_busy_addr", mem_if.address, 32'h0000_1000);
        chk("wr_busy_data", mem_if.writedata, 32'h1234_5678);
        chk("wr_busy_be", 32'(mem_if.byteenable), 32'hF);
        chk1("wr_busy_ce", cpu_clock_enable, 1'b0);
        step();
        chk1("wr_done_mem_write", mem_if.write, 1'b0);
        chk1("wr_done_ce", cpu_clock_enable, 1'b1);
        chk1("wr_done_err", bus_error, 1'b0);
        step();

        // read with 3 wait cycles, issued right after the write retires
        cpu_idle();
        cpu_if.address     = 32'h0000_1004;
        cpu_if.read        = 1'b1;
        mem_if.waitrequest = 1'b1;
        #1;
        chk1("rd_idle_mem_write", mem_if.write, 1'b0);
        n_stall = (cpu_clock_enable == 1'b0) ? 1 : 0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk1("rd_wait_mem_read", mem_if.read, 1'b1);
            chk("rd_wait_addr", mem_if.address, 32'h0000_1004);
            if (cpu_clock_enable == 1'b0) n_stall++;
            step();
        end
        mem_if.waitrequest = 1'b0;
        mem_if.readdata    = 32'hCAFE_F00D;
        #1;
        chk1("rd_last_mem_read", mem_if.read, 1'b1);
        chk("rd_last_be", 32'(mem_if.byteenable), 32'hF);
        if (cpu_clock_enable == 1'b0) n_stall++;
        step();
        mem_if.readdata = 32'h0;
        chk("rd_done_data", cpu_if.readdata, 32'hCAFE_F00D);
        chk1("rd_done_mem_read", mem_if.read, 1'b0);
        chk1("rd_done_ce", cpu_clock_enable, 1'b1);
        chk("rd_stall_cycles", 32'(n_stall), 32'd5);
        step();

        // back-to-back write after the read
        cpu_idle();
        cpu_if.address    = 32'h0000_1008;
        cpu_if.writedata  = 32'hA5A5_A5A5;
        cpu_if.byteenable = 4'h3;
        cpu_if.write      = 1'b1;
        #1;
        chk1("b2b_idle_no_dup_read", mem_if.read, 1'b0);
        step();
        chk1("b2b_busy_mem_write", mem_if.write, 1'b1);
        chk1("b2b_busy_mem_read", mem_if.read, 1'b0);
        chk("b2b_busy_addr", mem_if.address, 32'h0000_1008);
        chk("b2b_busy_be", 32'(mem_if.byteenable), 32'h3);
        step();
        chk1("b2b_done_mem_write", mem_if.write, 1'b0);
        chk("b2b_readdata_kept", cpu_if.readdata, 32'hCAFE_F00D);
        step();

        // reset in the middle of a waited write
        cpu_idle();
        cpu_if.address     = 32'h0000_3000;
        cpu_if.writedata   = 32'h1111_2222;
        cpu_if.byteenable  = 4'hF;
        cpu_if.write       = 1'b1;
        mem_if.waitrequest = 1'b1;
        step();
        step();
        chk1("rstmid_busy_mem_write", mem_if.write, 1'b1);
        #2;
        reset = 1'b1;
        cpu_idle();
        #1;
        chk1("rstmid_mem_write", mem_if.write, 1'b0);
        chk1("rstmid_ce", cpu_clock_enable, 1'b1);
        chk1("rstmid_err", bus_error, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // timeout: waitrequest stuck high on a read
        cpu_if.address = 32'h0000_2000;
        cpu_if.read    = 1'b1;
        step();
        chk1("to_busy_err", bus_error, 1'b0);
        n_busy = 0;
        while (mem_if.read === 1'b1 && n_busy < 20) begin
            n_busy++;
            step();
        end
        chk("to_busy_cycles", 32'(n_busy), 32'd8);
        chk1("to_err", bus_error, 1'b1);
        chk("to_readdata", cpu_if.readdata, 32'hDEAD_BEEF);
        chk1("to_done_ce", cpu_clock_enable, 1'b1);
        step();
        cpu_idle();
        mem_if.waitrequest = 1'b0;
        #1;
        chk1("to_resume_ce", cpu_clock_enable, 1'b1);
        chk1("to_err_sticky", bus_error, 1'b1);

        // clear the error, then a misaligned read
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk1("mis_pre_err", bus_error, 1'b0);
        step();
        cpu_if.address = 32'h0000_1002;
        cpu_if.read    = 1'b1;
        #1;
        chk1("mis_idle_ce", cpu_clock_enable, 1'b0);
        n_rd_seen = 0;
        step();
        if (mem_if.read === 1'b1) n_rd_seen++;
        chk("mis_readdata", cpu_if.readdata, 32'hDEAD_BEEF);
        chk1("mis_err", bus_error, 1'b1);
        chk1("mis_done_ce", cpu_clock_enable, 1'b1);
        step();
        cpu_idle();
        for (int i = 0; i < 10; i++) begin
            if (mem_if.read === 1'b1) n_rd_seen++;
            step();
        end
        chk("mis_no_mem_read", 32'(n_rd_seen), 32'd0);
        chk1("mis_err_sticky", bus_error, 1'b1);

        // read+write together is a conflict, also rejected
        cpu_if.address = 32'h0000_1010;
        cpu_if.read    = 1'b1;
        cpu_if.write   = 1'b1;
        step();
        chk1("conf_mem_read", mem_if.read, 1'b0);
        chk1("conf_mem_write", mem_if.write, 1'b0);
        chk("conf_readdata", cpu_if.readdata, 32'hDEAD_BEEF);
        step();
        cpu_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
